// File: rtl/serial_add_arbiter_if.sv
// Bus between two adder clients and serial_add_arbiter.
// SERIAL_ADD_OVF_EN adds the two's-complement overflow flag `ovf`.
interface serial_add_arbiter_if #(
   parameter int unsigned WIDTH = 8
);
   logic             req0;
   logic [WIDTH-1:0] a0;
   logic [WIDTH-1:0] b0;
   logic             ci0;
   logic             req1;
   logic [WIDTH-1:0] a1;
   logic [WIDTH-1:0] b1;
   logic             ci1;
   logic             busy;
   logic             grant_id;
   logic             done;
   logic [WIDTH-1:0] sum;
   logic             co;
`ifdef SERIAL_ADD_OVF_EN
   logic             ovf;
`endif

   // Client side: drives requests and operands, observes results.
   modport master (
      output req0, a0, b0, ci0, req1, a1, b1, ci1,
`ifdef SERIAL_ADD_OVF_EN
      input  ovf,
`endif
      input  busy, grant_id, done, sum, co
   );

   // Adder side.
   modport slave (
      input  req0, a0, b0, ci0, req1, a1, b1, ci1,
`ifdef SERIAL_ADD_OVF_EN
      output ovf,
`endif
      output busy, grant_id, done, sum, co
   );
endinterface

// File: rtl/serial_add_arbiter.sv
// Bit-serial WIDTH-bit adder built on one shared full adder, arbitrated
// round-robin between two requesters. LSB first, one bit per clock.
// SERIAL_ADD_OVF_EN adds the registered overflow output `ovf`.
module serial_add_arbiter #(
   parameter int unsigned WIDTH = 8
) (
   input logic                 clk,
   input logic                 rst_n,
   serial_add_arbiter_if.slave bus
);

   localparam int unsigned IdxW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [IdxW-1:0] IdxLast = IdxW'(WIDTH - 1);

   typedef enum logic [1:0] {StIdle, StCalc, StDone} state_e;

   state_e           state_q;
   logic [WIDTH-1:0] a_q, b_q, sum_sh_q, sum_q;
   logic [IdxW-1:0]  idx_q;
   logic             carry_q, co_q, grant_q, last_q, busy_q, done_q;
`ifdef SERIAL_ADD_OVF_EN
   logic             msb_carry_q, ovf_q;
`endif

   logic fa_a, fa_b, fa_s, fa_c;
   logic any_req, winner;

   // Shared full adder on the current bit, plus the round-robin pick.
   always_comb begin
      fa_a    = a_q[idx_q];
      fa_b    = b_q[idx_q];
      fa_s    = fa_a ^ fa_b ^ carry_q;
      fa_c    = (fa_a & fa_b) | (carry_q & (fa_a ^ fa_b));
      any_req = bus.req0 | bus.req1;
      // On a tie, the requester not served last wins; last_q resets to 1.
      winner  = ~(bus.req0 & (~bus.req1 | last_q));
   end

   // Controller FSM with registered outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= StIdle;
         a_q      <= '0;
         b_q      <= '0;
         sum_sh_q <= '0;
         sum_q    <= '0;
         idx_q    <= '0;
         carry_q  <= 1'b0;
         co_q     <= 1'b0;
         grant_q  <= 1'b0;
         last_q   <= 1'b1;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
`ifdef SERIAL_ADD_OVF_EN
         msb_carry_q <= 1'b0;
         ovf_q       <= 1'b0;
`endif
      end else begin
         done_q <= 1'b0;
         case (state_q)
            StIdle: begin
               if (any_req) begin
                  a_q     <= winner ? bus.a1 : bus.a0;
                  b_q     <= winner ? bus.b1 : bus.b0;
                  carry_q <= winner ? bus.ci1 : bus.ci0;
                  grant_q <= winner;
                  idx_q   <= '0;
                  busy_q  <= 1'b1;
                  state_q <= StCalc;
               end
            end
            StCalc: begin
               sum_sh_q[idx_q] <= fa_s;
               carry_q         <= fa_c;
`ifdef SERIAL_ADD_OVF_EN
               if (idx_q == IdxLast) msb_carry_q <= carry_q;
`endif
               if (idx_q == IdxLast) state_q <= StDone;
               else                  idx_q   <= idx_q + 1'b1;
            end
            StDone: begin
               // Results and done become visible together in the following cycle.
               done_q  <= 1'b1;
               sum_q   <= sum_sh_q;
               co_q    <= carry_q;
               last_q  <= grant_q;
               busy_q  <= 1'b0;
`ifdef SERIAL_ADD_OVF_EN
               ovf_q   <= msb_carry_q ^ carry_q;
`endif
               state_q <= StIdle;
            end
            default: state_q <= StIdle;
         endcase
      end
   end

   assign bus.busy     = busy_q;
   assign bus.grant_id = grant_q;
   assign bus.done     = done_q;
   assign bus.sum      = sum_q;
   assign bus.co       = co_q;
`ifdef SERIAL_ADD_OVF_EN
   assign bus.ovf      = ovf_q;
`endif

endmodule

// File: tb/tb_serial_add_arbiter.sv
// Scoreboard bench for serial_add_arbiter: requesters push expected results
// per requester; a monitor pops and compares on every done pulse.
module tb_serial_add_arbiter;

   localparam int unsigned W = 8;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   serial_add_arbiter_if #(.WIDTH(W)) bus ();
   serial_add_arbiter #(.WIDTH(W)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

   int          checks = 0;
   int          errors = 0;
   int unsigned cyc = 0;
   int unsigned last_done_cyc = 0;
   logic [W+1:0] exp_q0[$];   // {ovf, co, sum}
   logic [W+1:0] exp_q1[$];
   int           done_id[$];
   int unsigned  done_cyc[$];
   logic [W+1:0] held = '0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, req, $time);
      end
   endtask

   function automatic logic [W+1:0] model(input logic [W-1:0] a, b, input logic ci);
      longint u, s;
      logic [W:0] r;
      logic       v;
      u = longint'(a) + longint'(b) + longint'(ci);
      s = longint'($signed(a)) + longint'($signed(b)) + longint'(ci);
      r = u[W:0];
      v = (s > (longint'(1) << (W - 1)) - 1) || (s < -(longint'(1) << (W - 1)));
      return {v, r};
   endfunction

   // Monitor: compare every done pulse, and the hold of sum/co between pulses.
   always @(posedge clk) begin
      logic [W+1:0] e;
      cyc++;
      #1;
      if (!rst_n) begin
         held = '0;
      end else if (bus.done === 1'b1) begin
         done_id.push_back(int'(bus.grant_id));
         done_cyc.push_back(cyc);
         last_done_cyc = cyc;
         if ((bus.grant_id == 1'b0 && exp_q0.size() == 0) ||
             (bus.grant_id == 1'b1 && exp_q1.size() == 0)) begin
            checks++;
            errors++;
            $display("FAIL unexpected_done actual=done grant=%0d required=no_done", bus.grant_id);
         end else begin
            e = (bus.grant_id == 1'b0) ? exp_q0.pop_front() : exp_q1.pop_front();
            check("result_co_sum", 32'({bus.co, bus.sum}), 32'(e[W:0]));
`ifdef SERIAL_ADD_OVF_EN
            check("result_ovf", 32'(bus.ovf), 32'(e[W+1]));
`endif
            held = e;
         end
      end else begin
         check("hold_co_sum", 32'({bus.co, bus.sum}), 32'(held[W:0]));
`ifdef SERIAL_ADD_OVF_EN
         check("hold_ovf", 32'(bus.ovf), 32'(held[W+1]));
`endif
      end
   end

   task automatic raise(input int id, input logic [W-1:0] a, b, input logic ci);
      if (id == 0) begin
         bus.a0 = a; bus.b0 = b; bus.ci0 = ci; bus.req0 = 1'b1;
         exp_q0.push_back(model(a, b, ci));
      end else begin
         bus.a1 = a; bus.b1 = b; bus.ci1 = ci; bus.req1 = 1'b1;
         exp_q1.push_back(model(a, b, ci));
      end
   endtask

   // One complete request: raise, hold until own done, then drop.
   task automatic issue(input int id, input logic [W-1:0] a, b, input logic ci,
                        output int unsigned t_raise);
      bit got = 1'b0;
      @(negedge clk);
      t_raise = cyc;
      raise(id, a, b, ci);
      for (int i = 0; i < 200 && !got; i++) begin
         @(posedge clk);
         #2;
         if (bus.done === 1'b1 && bus.grant_id == 1'(id)) got = 1'b1;
      end
      if (id == 0) bus.req0 = 1'b0;
      else         bus.req1 = 1'b0;
      check($sformatf("done_seen_req%0d", id), 32'(got), 32'd1);
   endtask

   task automatic wait_busy();
      bit got = 1'b0;
      for (int i = 0; i < 20 && !got; i++) begin
         @(posedge clk);
         #2;
         if (bus.busy === 1'b1) got = 1'b1;
      end
      check("busy_after_grant", 32'(got), 32'd1);
   endtask

   task automatic wait_drained();
      bit ok = 1'b0;
      for (int i = 0; i < 500 && !ok; i++) begin
         @(posedge clk);
         #2;
         if (exp_q0.size() == 0 && exp_q1.size() == 0) ok = 1'b1;
      end
      check("queues_drained", 32'(ok), 32'd1);
   endtask

   task automatic check_reset_values(input string tag);
      check({tag, "_busy"}, 32'(bus.busy), 32'd0);
      check({tag, "_done"}, 32'(bus.done), 32'd0);
      check({tag, "_grant_id"}, 32'(bus.grant_id), 32'd0);
      check({tag, "_sum"}, 32'(bus.sum), 32'd0);
      check({tag, "_co"}, 32'(bus.co), 32'd0);
`ifdef SERIAL_ADD_OVF_EN
      check({tag, "_ovf"}, 32'(bus.ovf), 32'd0);
`endif
   endtask

   initial begin
      int unsigned t;
      int unsigned t0, t1;
      bus.req0 = 1'b0; bus.a0 = '0; bus.b0 = '0; bus.ci0 = 1'b0;
      bus.req1 = 1'b0; bus.a1 = '0; bus.b1 = '0; bus.ci1 = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check_reset_values("reset");
      @(negedge clk);
      rst_n = 1'b1;

      // Single requesters, latency from grant to done is W+1 clocks.
      issue(0, 8'h3C, 8'h05, 1'b0, t);
      check("latency_req0", last_done_cyc - t, W + 2);
      check("grant_id_req0", 32'(bus.grant_id), 32'd0);
      issue(1, 8'hFF, 8'h01, 1'b1, t);
      check("grant_id_req1", 32'(bus.grant_id), 32'd1);

      // Both requesting continuously: alternate, W+2 clocks apart.
      @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      done_id.delete();
      done_cyc.delete();
      fork
         begin
            issue(0, W'($urandom), W'($urandom), 1'($urandom), t0);
            issue(0, W'($urandom), W'($urandom), 1'($urandom), t0);
         end
         begin
            issue(1, W'($urandom), W'($urandom), 1'($urandom), t1);
            issue(1, W'($urandom), W'($urandom), 1'($urandom), t1);
         end
      join
      check("rr_count", done_id.size(), 4);
      for (int i = 0; i < 4 && i < done_id.size(); i++) begin
         check($sformatf("rr_order_%0d", i), done_id[i], i % 2);
         if (i > 0) check($sformatf("rr_spacing_%0d", i), done_cyc[i] - done_cyc[i-1], W + 2);
      end

      // Operands change and req drops after grant: latched values still used.
      @(negedge clk);
      raise(0, 8'h10, 8'h20, 1'b0);
      wait_busy();
      repeat (3) @(posedge clk);
      #2;
      bus.a0 = 8'hFF;
      bus.req0 = 1'b0;
      wait_drained();

      // Reset in the middle of CALC discards the operation.
      @(negedge clk);
      raise(1, 8'h5A, 8'h33, 1'b1);
      wait_busy();
      repeat (4) @(posedge clk);
      #2;
      rst_n = 1'b0;
      exp_q1.delete();
      bus.req1 = 1'b0;
      #1;
      check_reset_values("midop_reset");
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      issue(1, 8'hA5, 8'h0F, 1'b0, t);

      // Corner operands, including the overflow cases.
      issue(0, 8'h7F, 8'h01, 1'b0, t);
      issue(1, 8'hFF, 8'h01, 1'b0, t);
      issue(0, 8'h00, 8'h00, 1'b0, t);
      issue(1, 8'hFF, 8'hFF, 1'b1, t);
      issue(0, 8'h80, 8'h80, 1'b0, t);

      // Random traffic from both requesters with random gaps.
      for (int r = 0; r < 25; r++) begin
         fork
            begin
               int unsigned tt;
               repeat ($urandom_range(1, 3)) begin
                  repeat ($urandom_range(0, 3)) @(negedge clk);
                  issue(0, W'($urandom), W'($urandom), 1'($urandom), tt);
               end
            end
            begin
               int unsigned tt;
               repeat ($urandom_range(1, 3)) begin
                  repeat ($urandom_range(0, 3)) @(negedge clk);
                  issue(1, W'($urandom), W'($urandom), 1'($urandom), tt);
               end
            end
         join
      end
      wait_drained();
      repeat (3) @(posedge clk);
      #3;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
